resampler_frame_ctrl: RTL and testbench



---
 rtl/resampler_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_resampler_frame_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resampler_frame_ctrl.sv
// resampler_frame_ctrl: frame sequencer between the FFT output stream and the
// resampler. Forwards one frame at a time through a registered valid/ready
// stage, checks bin-index continuity, latches the pitch scale factor on frame
// boundaries and holds off the FFT until the resampler finishes the frame.
//
// Build option: define RESAMP_CTRL_OVERLAP_EN to drop the WAIT_DONE hold-off;
// the frame is then counted when the rs_last beat is taken by the resampler
// and rs_done is ignored.
module resampler_frame_ctrl #(
   parameter int unsigned     N_BINS     = 2048,
   parameter int unsigned     BIN_W      = 11,
   parameter int unsigned     DATA_W     = 80,
   parameter int unsigned     SF_W       = 24,
   parameter logic [SF_W-1:0] SF_DEFAULT = SF_W'(24'h100000),
   parameter int unsigned     CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] fft_data,
   input  logic [BIN_W-1:0]  fft_user,
   input  logic              fft_valid,
   input  logic              fft_last,
   output logic              fft_ready,
   input  logic [SF_W-1:0]   sf_in,
   input  logic              sf_in_valid,
   output logic [DATA_W-1:0] rs_data,
   output logic [BIN_W-1:0]  rs_user,
   output logic              rs_valid,
   output logic              rs_last,
   input  logic              rs_ready,
   output logic [SF_W-1:0]   rs_scale_factor,
   output logic              rs_scale_factor_valid,
   input  logic              rs_done,
   output logic              rs_abort,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_count,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      SKIP      = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [BIN_W-1:0]  exp_bin;
   logic [SF_W-1:0]   sf_pending;

   logic              accept_c;
   logic              bin_ok_c;
   logic              last_bin_c;
   logic              last_ok_c;
   logic              start_c;
   logic              fwd_c;
   logic              err_c;
   logic              abort_c;
   logic              sf_ok_c;
   logic              frame_done_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_c) state_nxt = RUN;
         end
         RUN: begin
            if (accept_c) begin
               if (!(bin_ok_c && last_ok_c)) begin
                  state_nxt = fft_last ? IDLE : SKIP;
               end else if (last_bin_c) begin
`ifdef RESAMP_CTRL_OVERLAP_EN
                  state_nxt = IDLE;
`else
                  state_nxt = WAIT_DONE;
`endif
               end
            end
         end
         SKIP: begin
            if (accept_c && fft_last) state_nxt = IDLE;
         end
         WAIT_DONE: begin
            if (rs_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and beat classification
   always_comb begin
      fft_ready    = 1'b0;
      busy         = 1'b0;
      accept_c     = 1'b0;
      bin_ok_c     = 1'b0;
      last_bin_c   = 1'b0;
      last_ok_c    = 1'b0;
      start_c      = 1'b0;
      fwd_c        = 1'b0;
      err_c        = 1'b0;
      abort_c      = 1'b0;
      sf_ok_c      = 1'b0;
      frame_done_c = 1'b0;

      fft_ready  = (state != WAIT_DONE) && (!rs_valid || rs_ready);
      busy       = (state != IDLE);
      accept_c   = fft_valid && fft_ready;
      bin_ok_c   = (fft_user == exp_bin);
      last_bin_c = (exp_bin == BIN_W'(N_BINS - 1));
      last_ok_c  = (fft_last == last_bin_c);
      sf_ok_c    = sf_in_valid && (sf_in != '0);

      if (state == IDLE && accept_c) begin
         start_c = (fft_user == '0);
         err_c   = (fft_user != '0);
      end
      if (state == RUN && accept_c) begin
         fwd_c   = bin_ok_c && last_ok_c;
         abort_c = !(bin_ok_c && last_ok_c);
         err_c   = abort_c;
      end
      fwd_c = fwd_c || start_c;

`ifdef RESAMP_CTRL_OVERLAP_EN
      frame_done_c = rs_valid && rs_ready && rs_last;
`else
      frame_done_c = (state == WAIT_DONE) && rs_done;
`endif
   end

`ifdef RESAMP_CTRL_OVERLAP_EN
   logic unused_rs_done;
   assign unused_rs_done = rs_done;
`endif

   // Output register, scale-factor latch, bin tracking and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_data               <= '0;
         rs_user               <= '0;
         rs_valid              <= 1'b0;
         rs_last               <= 1'b0;
         rs_abort              <= 1'b0;
         rs_scale_factor       <= SF_DEFAULT;
         rs_scale_factor_valid <= 1'b0;
         sf_pending            <= SF_DEFAULT;
         exp_bin               <= '0;
         frame_count           <= '0;
         err_count             <= '0;
      end else begin
         rs_scale_factor_valid <= 1'b1;
         rs_abort              <= abort_c;

         if (sf_ok_c) sf_pending <= sf_in;

         if (fwd_c) begin
            rs_valid <= 1'b1;
            rs_data  <= fft_data;
            rs_user  <= fft_user;
            rs_last  <= (state == RUN) && last_bin_c;
         end else if (rs_ready) begin
            rs_valid <= 1'b0;
            rs_last  <= 1'b0;
         end

         // New frame: bypass a same-cycle strobe, else take the pending value
         if (start_c) begin
            rs_scale_factor <= sf_ok_c ? sf_in : sf_pending;
            exp_bin         <= BIN_W'(1);
         end else if (fwd_c) begin
            exp_bin <= exp_bin + BIN_W'(1);
         end

         if (err_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (frame_done_c) frame_count <= frame_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_resampler_frame_ctrl.sv
// Scoreboard bench for resampler_frame_ctrl: a stream-level reference model
// predicts forwarded beats and counters; a monitor pops and compares.
module tb_resampler_frame_ctrl;

   localparam int unsigned N_BINS = 2048;
   localparam int unsigned BIN_W  = 11;
   localparam int unsigned DATA_W = 80;
   localparam int unsigned SF_W   = 24;
   localparam int unsigned CNT_W  = 16;
   localparam logic [SF_W-1:0] SF_DEF = 24'h100000;
   localparam int BOUND = 64;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] fft_data;
   logic [BIN_W-1:0]  fft_user;
   logic              fft_valid;
   logic              fft_last;
   logic              fft_ready;
   logic [SF_W-1:0]   sf_in;
   logic              sf_in_valid;
   logic [DATA_W-1:0] rs_data;
   logic [BIN_W-1:0]  rs_user;
   logic              rs_valid;
   logic              rs_last;
   logic              rs_ready;
   logic [SF_W-1:0]   rs_scale_factor;
   logic              rs_scale_factor_valid;
   logic              rs_done;
   logic              rs_abort;
   logic              busy;
   logic [CNT_W-1:0]  frame_count;
   logic [7:0]        err_count;

   typedef struct {
      logic [BIN_W-1:0]  u;
      logic [DATA_W-1:0] d;
      logic              l;
      logic [SF_W-1:0]   sf;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_b;

   int n_vec = 0;
   int n_err = 0;
   int rdy_mode = 0;

   // Reference model: where we are in the input stream
   // next_bin >= 0: inside a frame expecting that bin; -1: awaiting bin 0;
   // -2: discarding to end of frame; -3: frame complete, awaiting rs_done
   int next_bin;
   logic [SF_W-1:0] m_pend;
   logic [SF_W-1:0] m_act;
   int m_errs, m_frames, m_aborts, seen_aborts;

   logic held;
   logic [DATA_W-1:0] held_d;
   logic [BIN_W-1:0]  held_u;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   resampler_frame_ctrl dut (
      .clk(clk), .rst(rst),
      .fft_data(fft_data), .fft_user(fft_user), .fft_valid(fft_valid),
      .fft_last(fft_last), .fft_ready(fft_ready),
      .sf_in(sf_in), .sf_in_valid(sf_in_valid),
      .rs_data(rs_data), .rs_user(rs_user), .rs_valid(rs_valid),
      .rs_last(rs_last), .rs_ready(rs_ready),
      .rs_scale_factor(rs_scale_factor),
      .rs_scale_factor_valid(rs_scale_factor_valid),
      .rs_done(rs_done), .rs_abort(rs_abort), .busy(busy),
      .frame_count(frame_count), .err_count(err_count)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DATA_W-1:0];
   endfunction

   task automatic model_reset();
      next_bin = -1;
      m_pend   = SF_DEF;
      m_act    = SF_DEF;
      m_errs   = 0;
      m_frames = 0;
      m_aborts = 0;
   endtask

   function automatic void add_err();
      if (m_errs < 255) m_errs++;
   endfunction

   // Apply the framing rules to one accepted input beat
   task automatic model_beat(input int u, input logic l, input logic [DATA_W-1:0] d);
      beat_t b;
      if (next_bin == -1) begin
         if (u == 0) begin
            m_act = m_pend;
            b.u = BIN_W'(u); b.d = d; b.l = 1'b0; b.sf = m_act;
            exp_q.push_back(b);
            next_bin = 1;
         end else begin
            add_err();
         end
      end else if (next_bin >= 0) begin
         if (u == next_bin && l == (next_bin == N_BINS - 1)) begin
            b.u = BIN_W'(u); b.d = d; b.l = l; b.sf = m_act;
            exp_q.push_back(b);
            next_bin = l ? -3 : next_bin + 1;
         end else begin
            add_err();
            m_aborts++;
            next_bin = l ? -1 : -2;
         end
      end else if (next_bin == -2) begin
         if (l) next_bin = -1;
      end
   endtask

   task automatic model_done();
      if (next_bin == -3) begin
         m_frames++;
         next_bin = -1;
      end
   endtask

   // Present one beat (optionally with a scale-factor strobe) until accepted
   task automatic send_beat(input int u, input logic l, input logic sfv, input logic [SF_W-1:0] sf);
      logic [DATA_W-1:0] d;
      d = rnd_data();
      fft_user = BIN_W'(u); fft_last = l; fft_data = d; fft_valid = 1'b1;
      sf_in = sf; sf_in_valid = sfv;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk);
         if (c == 0 && sfv && sf != '0) m_pend = sf;
         if (fft_ready) begin
            model_beat(u, l, d);
            step();
            fft_valid = 1'b0; sf_in_valid = 1'b0; fft_last = 1'b0;
            return;
         end
         step();
         sf_in_valid = 1'b0;
      end
      fft_valid = 1'b0; fft_last = 1'b0;
      n_vec++; n_err++;
      $display("FAIL fft_ready_timeout: bin %0d not accepted within %0d cycles", u, BOUND);
   endtask

   task automatic send_range(input int lo, input int hi, input int last_at);
      for (int b = lo; b <= hi; b++) send_beat(b, b == last_at, 1'b0, '0);
   endtask

   // Drain output, confirm hold-off, then release with rs_done
   task automatic finish_frame();
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk);
         if (!rs_valid) break;
      end
      chk("wait_drained", 128'(rs_valid), 128'(0));
      chk("wait_fft_ready_low", 128'(fft_ready), 128'(0));
      chk("wait_busy", 128'(busy), 128'(1));
      step();
      rs_done = 1'b1;
      step();
      rs_done = 1'b0;
      model_done();
      @(negedge clk);
      chk("frame_count", 128'(frame_count), 128'(m_frames));
      chk("idle_after_done", 128'(busy), 128'(0));
      step();
   endtask

   // Resampler back-pressure pattern
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       rs_ready = 1'b1;
         1:       rs_ready = ~rs_ready;
         default: rs_ready = ($urandom_range(3) != 0);
      endcase
   end

   // Monitor: compare each beat taken by the resampler against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", 128'(rs_valid), 128'(1));
            chk("stall_data", 128'(rs_data), 128'(held_d));
            chk("stall_user", 128'(rs_user), 128'(held_u));
         end
         if (rs_abort) begin
            seen_aborts++;
            chk("abort_with_valid", 128'(rs_valid), 128'(0));
         end
         if (rs_valid && rs_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_beat: got user %0d expected none", rs_user);
            end else begin
               mon_b = exp_q.pop_front();
               chk("rs_user", 128'(rs_user), 128'(mon_b.u));
               chk("rs_data", 128'(rs_data), 128'(mon_b.d));
               chk("rs_last", 128'(rs_last), 128'(mon_b.l));
               chk("rs_scale_factor", 128'(rs_scale_factor), 128'(mon_b.sf));
            end
         end
         held   = rs_valid && !rs_ready;
         held_d = rs_data;
         held_u = rs_user;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; fft_valid = 1'b0; fft_last = 1'b0; fft_user = '0; fft_data = '0;
      sf_in = '0; sf_in_valid = 1'b0; rs_done = 1'b0; rs_ready = 1'b1;
      seen_aborts = 0; held = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rs_valid", 128'(rs_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_sf", 128'(rs_scale_factor), 128'(SF_DEF));
      chk("rst_sf_valid", 128'(rs_scale_factor_valid), 128'(0));
      chk("rst_frame_count", 128'(frame_count), 128'(0));
      chk("rst_err_count", 128'(err_count), 128'(0));
      chk("rst_abort", 128'(rs_abort), 128'(0));
      rst = 1'b0;
      step();
      chk("sf_valid_after_rst", 128'(rs_scale_factor_valid), 128'(1));

      // rs_done outside WAIT_DONE has no effect
      rs_done = 1'b1; step(); rs_done = 1'b0; step();
      chk("done_ignored_idle", 128'(frame_count), 128'(0));

      // Frame A: full ready, scale change and a zero strobe mid-frame
      rdy_mode = 0;
      send_range(0, 999, -1);
      send_beat(1000, 1'b0, 1'b1, 24'h080000);
      send_range(1001, 1499, -1);
      send_beat(1500, 1'b0, 1'b1, 24'h000000);
      send_range(1501, 2047, 2047);
      finish_frame();

      // Frame B: alternating back-pressure, new scale factor applies
      rdy_mode = 1;
      send_range(0, 2047, 2047);
      finish_frame();

      // Frame C: bin gap 100 -> 102, swallowed until fft_last
      rdy_mode = 2;
      send_range(0, 100, -1);
      send_range(102, 300, 300);
      @(negedge clk);
      chk("gap_err_count", 128'(err_count), 128'(m_errs));
      chk("gap_aborts", 128'(seen_aborts), 128'(m_aborts));
      chk("gap_idle", 128'(busy), 128'(0));
      step();

      // Frame D: clean frame after the error
      send_range(0, 2047, 2047);
      finish_frame();

      // Frame E: early fft_last at 1000, then stray bin 1001 in IDLE
      send_range(0, 999, -1);
      send_beat(1000, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("early_last_idle", 128'(busy), 128'(0));
      step();
      send_beat(1001, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) send_beat(int'($urandom_range(1, N_BINS - 1)), 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("stray_err_count", 128'(err_count), 128'(m_errs));
      chk("abort_total", 128'(seen_aborts), 128'(m_aborts));
      step();

      // Asynchronous reset in the middle of a frame
      rdy_mode = 0;
      send_beat(0, 1'b0, 1'b1, 24'h0C0000);
      send_range(1, 500, -1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_rs_valid", 128'(rs_valid), 128'(0));
      chk("midrst_busy", 128'(busy), 128'(0));
      chk("midrst_sf", 128'(rs_scale_factor), 128'(SF_DEF));
      exp_q.delete();
      model_reset();
      seen_aborts = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      chk("midrst_err_count", 128'(err_count), 128'(0));
      chk("midrst_frame_count", 128'(frame_count), 128'(0));

      // Fresh frame after reset
      rdy_mode = 2;
      send_range(0, 2047, 2047);
      finish_frame();

      repeat (4) step();
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      chk("final_err_count", 128'(err_count), 128'(m_errs));
      chk("final_frame_count", 128'(frame_count), 128'(m_frames));
      chk("final_aborts", 128'(seen_aborts), 128'(m_aborts));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
